pe_issue_ctrl: RTL and testbench

- Initiator-side controller that drives one mixed-radix butterfly PE (pe0/pe3 class) and collects its U/V results.
- Accepts operand tuples (A, B, W, TF, mode) on a valid/ready stream and issues them to the PE with `ctrl`/`valid` held steady.
- Enforces the PE usage rule: drain the pipeline before any mode switch.
- The PE pipeline cannot stall, so a credit scheme guarantees that every issued op has a slot in the internal result FIFO. This makes result backpressure safe.

---
 rtl/pe_issue_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_pe_issue_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_issue_ctrl.sv
// pe_issue_ctrl: drives one mixed-radix butterfly PE and collects its U/V results.
// Tuples are issued with registered ctrl/valid/operands. A mode change first drains
// the PE pipeline. Every issued op owns a result FIFO slot (credit scheme), so the
// non-stallable PE can never overflow the FIFO even while results are backpressured.
//
// Handshake rule used on both streams: a transfer happens on a rising clk edge where
// valid and ready are both high. Valid must not depend on ready. A producer holding
// valid keeps its payload stable until the transfer.

package poly_arith_pkg;
    localparam int COEFF_WIDTH = 12;

    typedef enum logic [2:0] {
        PE_MODE_NTT    = 3'd0,
        PE_MODE_INTT   = 3'd1,
        PE_MODE_CWM    = 3'd2,
        PE_MODE_COMP   = 3'd3,
        PE_MODE_DECOMP = 3'd4,
        PE_MODE_ADDSUB = 3'd5
    } pe_mode_e;

    typedef enum logic [1:0] {
        ST_ISSUE  = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_SWITCH = 2'd2
    } issue_state_e;
endpackage

module pe_issue_ctrl
    import poly_arith_pkg::*;
#(
    parameter int RES_DEPTH = 8,
    parameter int COEFF_W   = COEFF_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    // operand tuple stream
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  pe_mode_e           in_mode_i,
    input  logic [COEFF_W-1:0] in_a_i,
    input  logic [COEFF_W-1:0] in_b_i,
    input  logic [COEFF_W-1:0] in_w_i,
    input  logic [COEFF_W-1:0] in_tf_i,
    // PE issue side
    output pe_mode_e           pe_ctrl_o,
    output logic               pe_valid_o,
    output logic [COEFF_W-1:0] pe_a_o,
    output logic [COEFF_W-1:0] pe_b_o,
    output logic [COEFF_W-1:0] pe_w_o,
    output logic [COEFF_W-1:0] pe_tf_o,
    // PE result side
    input  logic               pe_valid_i,
    input  logic [COEFF_W-1:0] pe_u_i,
    input  logic [COEFF_W-1:0] pe_v_i,
    // result stream
    output logic               res_valid_o,
    input  logic               res_ready_i,
    output logic [COEFF_W-1:0] res_u_o,
    output logic [COEFF_W-1:0] res_v_o,
    // status
    output logic               busy_o,
    output logic               err_o,
    output issue_state_e       state_o
);

    localparam int CNT_W   = $clog2(RES_DEPTH + 1);
    localparam int PTR_W   = $clog2(RES_DEPTH);
    localparam int ENTRY_W = 2 * COEFF_W;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RES_DEPTH);
    localparam logic [CNT_W:0]   DEPTH_X = (CNT_W + 1)'(RES_DEPTH);

    issue_state_e       state_q, state_d;
    pe_mode_e           ctrl_q, ctrl_d;
    pe_mode_e           next_mode_q, next_mode_d;
    logic               pe_valid_q, pe_valid_d;
    logic [COEFF_W-1:0] a_q, a_d, b_q, b_d, w_q, w_d, tf_q, tf_d;
    logic [CNT_W-1:0]   inflight_q, inflight_d;
    logic [CNT_W-1:0]   fifo_cnt_q, fifo_cnt_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic               err_q, err_d;
    // Low during reset and for the first cycle after, so in_ready_o is 0 while in reset.
    logic               ready_en_q, ready_en_d;

    logic [ENTRY_W-1:0] fifo_mem [RES_DEPTH];
    logic [ENTRY_W-1:0] head;

    logic mode_match, credit_ok, in_ready, issue;
    logic pop, rsp_ok, fifo_full, push, err_hit;

    // Credits: in-flight ops plus buffered results never exceed the FIFO depth.
    // The pre-pop count is used, so a pop frees its credit one cycle later.
    assign mode_match = (in_mode_i == ctrl_q);
    assign credit_ok  = ({1'b0, inflight_q} + {1'b0, fifo_cnt_q}) < DEPTH_X;
    assign in_ready   = ready_en_q && (state_q == ST_ISSUE) && mode_match && credit_ok;
    assign issue      = in_valid_i && in_ready;

    // A PE response with nothing in flight, or one arriving at a full FIFO with no pop,
    // is a protocol error and is dropped.
    assign pop       = (fifo_cnt_q != '0) && res_ready_i;
    assign rsp_ok    = pe_valid_i && (inflight_q != '0);
    assign fifo_full = (fifo_cnt_q == DEPTH_C);
    assign push      = rsp_ok && (!fifo_full || pop);
    assign err_hit   = pe_valid_i && ((inflight_q == '0) || (fifo_full && !pop));

    assign head = fifo_mem[rd_ptr_q];

    // Next-state computation for the FSM, issue registers, counters and FIFO pointers.
    always_comb begin
        state_d     = state_q;
        ctrl_d      = ctrl_q;
        next_mode_d = next_mode_q;
        pe_valid_d  = issue;
        a_d         = a_q;
        b_d         = b_q;
        w_d         = w_q;
        tf_d        = tf_q;
        inflight_d  = inflight_q;
        fifo_cnt_d  = fifo_cnt_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        err_d       = err_q | err_hit;
        ready_en_d  = 1'b1;

        if (issue) begin
            a_d  = in_a_i;
            b_d  = in_b_i;
            w_d  = in_w_i;
            tf_d = in_tf_i;
        end

        case (state_q)
            ST_ISSUE: begin
                if (in_valid_i && !mode_match) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Buffered results do not hold up the drain, only ops still in the PE.
                if (inflight_q == '0) begin
                    next_mode_d = in_mode_i;
                    state_d     = ST_SWITCH;
                end
            end
            ST_SWITCH: begin
                ctrl_d  = next_mode_q;
                state_d = ST_ISSUE;
            end
            default: begin
                state_d = ST_ISSUE;
            end
        endcase

        case ({issue, rsp_ok})
            2'b10:   inflight_d = inflight_q + CNT_W'(1);
            2'b01:   inflight_d = inflight_q - CNT_W'(1);
            default: inflight_d = inflight_q;
        endcase

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    // State register for the FSM and every control/issue flop; reset discards all work.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_ISSUE;
            ctrl_q      <= PE_MODE_NTT;
            next_mode_q <= PE_MODE_NTT;
            pe_valid_q  <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            w_q         <= '0;
            tf_q        <= '0;
            inflight_q  <= '0;
            fifo_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            err_q       <= 1'b0;
            ready_en_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ctrl_q      <= ctrl_d;
            next_mode_q <= next_mode_d;
            pe_valid_q  <= pe_valid_d;
            a_q         <= a_d;
            b_q         <= b_d;
            w_q         <= w_d;
            tf_q        <= tf_d;
            inflight_q  <= inflight_d;
            fifo_cnt_q  <= fifo_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            err_q       <= err_d;
            ready_en_q  <= ready_en_d;
        end
    end

    // Result storage; contents are only observable through a non-zero count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {pe_u_i, pe_v_i};
        end
    end

    assign in_ready_o  = in_ready;
    assign pe_ctrl_o   = ctrl_q;
    assign pe_valid_o  = pe_valid_q;
    assign pe_a_o      = a_q;
    assign pe_b_o      = b_q;
    assign pe_w_o      = w_q;
    assign pe_tf_o     = tf_q;
    assign res_valid_o = (fifo_cnt_q != '0);
    assign res_u_o     = res_valid_o ? head[ENTRY_W-1:COEFF_W] : '0;
    assign res_v_o     = res_valid_o ? head[COEFF_W-1:0] : '0;
    assign busy_o      = (inflight_q != '0) || (fifo_cnt_q != '0) || (state_q != ST_ISSUE);
    assign err_o       = err_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_pe_issue_ctrl.sv
// Bench for pe_issue_ctrl: behavioural PE with mode-dependent latency
// (u = a + b, v = w ^ tf), tuple driver, in-order result scoreboard.
module tb_pe_issue_ctrl;
    import poly_arith_pkg::*;

    localparam int W = 12;

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // DUT signals
    logic         in_valid_i;
    logic         in_ready_o;
    pe_mode_e     in_mode_i;
    logic [W-1:0] in_a_i, in_b_i, in_w_i, in_tf_i;
    pe_mode_e     pe_ctrl_o;
    logic         pe_valid_o;
    logic [W-1:0] pe_a_o, pe_b_o, pe_w_o, pe_tf_o;
    logic         pe_valid_i = 1'b0;
    logic [W-1:0] pe_u_i = '0;
    logic [W-1:0] pe_v_i = '0;
    logic         res_valid_o;
    logic         res_ready_i;
    logic [W-1:0] res_u_o, res_v_o;
    logic         busy_o, err_o;
    issue_state_e state_o;

    pe_issue_ctrl #(.RES_DEPTH(8), .COEFF_W(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_mode_i(in_mode_i),
        .in_a_i(in_a_i), .in_b_i(in_b_i), .in_w_i(in_w_i), .in_tf_i(in_tf_i),
        .pe_ctrl_o(pe_ctrl_o), .pe_valid_o(pe_valid_o),
        .pe_a_o(pe_a_o), .pe_b_o(pe_b_o), .pe_w_o(pe_w_o), .pe_tf_o(pe_tf_o),
        .pe_valid_i(pe_valid_i), .pe_u_i(pe_u_i), .pe_v_i(pe_v_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
        .res_u_o(res_u_o), .res_v_o(res_v_o),
        .busy_o(busy_o), .err_o(err_o), .state_o(state_o)
    );

    // counters and scoreboard
    int total = 0;
    int bad = 0;
    int n_res = 0;
    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] exp_head;
    pe_mode_e last_mode = PE_MODE_NTT;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int pe_lat(input pe_mode_e m);
        case (m)
            PE_MODE_COMP, PE_MODE_DECOMP: return 3;
            PE_MODE_ADDSUB:               return 1;
            default:                      return 4;
        endcase
    endfunction

    // PE model: op seen on pe_valid_o in cycle t returns on pe_valid_i in cycle t+L
    logic         sv_v[16] = '{default: 1'b0};
    logic [W-1:0] sv_u[16] = '{default: '0};
    logic [W-1:0] sv_w[16] = '{default: '0};
    int n_edge = 0;
    int slot;
    logic inj_req = 1'b0;
    always @(posedge clk) begin
        if (pe_valid_o) begin
            slot = (n_edge + pe_lat(pe_ctrl_o) - 1) % 16;
            sv_v[slot] = 1'b1;
            sv_u[slot] = pe_a_o + pe_b_o;
            sv_w[slot] = pe_w_o ^ pe_tf_o;
        end
        #1;
        pe_valid_i = sv_v[n_edge % 16];
        pe_u_i     = sv_u[n_edge % 16];
        pe_v_i     = sv_w[n_edge % 16];
        sv_v[n_edge % 16] = 1'b0;
        if (inj_req) begin
            pe_valid_i = 1'b1;
            pe_u_i     = 12'hABC;
            pe_v_i     = 12'h123;
            inj_req    = 1'b0;
        end
        n_edge++;
    end

    // monitors: result scoreboard, pe_valid_o run length, first-result latency, FSM rules
    int pv_run = 0;
    int pv_max = 0;
    logic res_arm = 1'b0;
    int res_arm_hs = 0;
    int res_lat_got = -1;
    always @(negedge clk) begin
        if (rst && res_valid_o && res_ready_i) begin
            if (exp_q.size() == 0) begin
                check("res_unexpected", 32'd1, 32'd0);
            end else begin
                exp_head = exp_q.pop_front();
                check("res_data", {8'd0, res_u_o, res_v_o}, {8'd0, exp_head});
            end
            n_res++;
        end
        if (pe_valid_o) pv_run++;
        else pv_run = 0;
        if (pv_run > pv_max) pv_max = pv_run;
        if (res_arm && res_valid_o) begin
            res_lat_got = cyc - res_arm_hs;
            res_arm = 1'b0;
        end
        if (rst && state_o != ST_ISSUE) check("no_issue_in_drain_switch", {31'd0, pe_valid_o}, 32'd0);
        if (rst && state_o == ST_DRAIN) check("ctrl_hold_in_drain", {29'd0, pe_ctrl_o}, {29'd0, last_mode});
    end

    // driver: present a tuple at posedge+1, wait for handshake, return in the next cycle
    task automatic send(input pe_mode_e m, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] w, input logic [W-1:0] tf, output int hs);
        bit done;
        done = 1'b0;
        hs = -1;
        in_mode_i = m; in_a_i = a; in_b_i = b; in_w_i = w; in_tf_i = tf;
        in_valid_i = 1'b1;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            if (in_ready_o) begin
                done = 1'b1;
                hs = cyc;
                exp_q.push_back({a + b, w ^ tf});
                last_mode = m;
            end
            @(posedge clk); #1;
        end
        in_valid_i = 1'b0;
        if (!done) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        bit idle;
        idle = 1'b0;
        for (int k = 0; k < 300 && !idle; k++) begin
            @(negedge clk);
            if (!busy_o) idle = 1'b1;
        end
        check(tag, {31'd0, idle}, 32'd1);
    endtask

    int hs, hs_prev, hl, p, base;
    logic [W-1:0] t9_a, t9_b;

    initial begin
        rst = 1'b1;
        in_valid_i = 1'b0; in_mode_i = PE_MODE_NTT;
        in_a_i = '0; in_b_i = '0; in_w_i = '0; in_tf_i = '0;
        res_ready_i = 1'b1;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pe_ctrl", {29'd0, pe_ctrl_o}, {29'd0, PE_MODE_NTT});
        check("rst_pe_valid", {31'd0, pe_valid_o}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready_o}, 32'd0);
        check("rst_res_valid", {31'd0, res_valid_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_err", {31'd0, err_o}, 32'd0);
        check("rst_state", {30'd0, state_o}, {30'd0, ST_ISSUE});
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;

        // single ADDSUB op (switches from NTT first)
        send(PE_MODE_ADDSUB, 12'h002, 12'h003, 12'h0F0, 12'h00F, hs);
        @(negedge clk);
        check("t1_pe_valid", {31'd0, pe_valid_o}, 32'd1);
        check("t1_pe_ctrl", {29'd0, pe_ctrl_o}, {29'd0, PE_MODE_ADDSUB});
        check("t1_pe_a", {20'd0, pe_a_o}, 32'h002);
        @(negedge clk);
        check("t1_res_not_yet", {31'd0, res_valid_o}, 32'd0);
        check("t1_single_strobe", {31'd0, pe_valid_o}, 32'd0);
        @(negedge clk);
        check("t1_res_valid", {31'd0, res_valid_o}, 32'd1);
        check("t1_res_u", {20'd0, res_u_o}, 32'h005);
        check("t1_res_v", {20'd0, res_v_o}, 32'h0FF);
        @(negedge clk);
        check("t1_busy_after_pop", {31'd0, busy_o}, 32'd0);
        @(posedge clk); #1;

        // 8 back-to-back NTT ops
        pv_max = 0; res_lat_got = -1;
        for (int i = 0; i < 8; i++) begin
            send(PE_MODE_NTT, W'(i + 16), W'(3 * i), W'(5 * i), 12'h055, hs);
            if (i == 0) begin
                res_arm_hs = hs; res_arm = 1'b1;
            end else begin
                check("t2_back_to_back", hs - hs_prev, 32'd1);
            end
            hs_prev = hs;
        end
        wait_idle("t2_idle");
        check("t2_first_res_lat", res_lat_got, 32'd6);
        check("t2_pe_valid_run", pv_max, 32'd8);
        check("t2_err", {31'd0, err_o}, 32'd0);
        check("t2_all_popped", exp_q.size(), 32'd0);
        @(posedge clk); #1;

        // credit limit with result backpressure
        res_ready_i = 1'b0;
        base = n_res;
        for (int i = 0; i < 8; i++) begin
            send(PE_MODE_NTT, W'($urandom_range(0, 4095)), W'($urandom_range(0, 4095)),
                 W'($urandom_range(0, 4095)), W'($urandom_range(0, 4095)), hs);
        end
        t9_a = W'($urandom_range(0, 4095));
        t9_b = W'($urandom_range(0, 4095));
        in_mode_i = PE_MODE_NTT; in_a_i = t9_a; in_b_i = t9_b; in_w_i = 12'h111; in_tf_i = 12'h222;
        in_valid_i = 1'b1;
        repeat (20) @(negedge clk);
        check("t3_blocked", {31'd0, in_ready_o}, 32'd0);
        check("t3_res_held", {31'd0, res_valid_o}, 32'd1);
        check("t3_no_pops", n_res - base, 32'd0);
        @(posedge clk); #1 res_ready_i = 1'b1;
        @(negedge clk);
        p = cyc;
        check("t3_prepop_credit", {31'd0, in_ready_o}, 32'd0);
        @(posedge clk); #1;
        send(PE_MODE_NTT, t9_a, t9_b, 12'h111, 12'h222, hs);
        check("t3_credit_return", hs - p, 32'd1);
        for (int i = 0; i < 3; i++) begin
            send(PE_MODE_NTT, W'($urandom_range(0, 4095)), W'($urandom_range(0, 4095)),
                 W'(i), 12'hFFF, hs);
        end
        wait_idle("t3_idle");
        check("t3_all_results", n_res - base, 32'd12);
        check("t3_err", {31'd0, err_o}, 32'd0);
        @(posedge clk); #1;

        // NTT stream then COMP: drain, switch, COMP latency
        for (int i = 0; i < 4; i++) begin
            send(PE_MODE_NTT, W'(100 + i), W'(7 * i), 12'h3C3, W'(i), hs);
        end
        hl = hs;
        res_lat_got = -1;
        send(PE_MODE_COMP, 12'h7FF, 12'h801, 12'hAAA, 12'h555, hs);
        res_arm_hs = hs; res_arm = 1'b1;
        check("t4_drain_to_issue", hs - hl, 32'd8);
        wait_idle("t4_idle");
        check("t4_comp_lat", res_lat_got, 32'd5);
        check("t4_ctrl_new", {29'd0, pe_ctrl_o}, {29'd0, PE_MODE_COMP});
        check("t4_all_popped", exp_q.size(), 32'd0);

        // spurious PE response with nothing in flight
        check("t6_err_before", {31'd0, err_o}, 32'd0);
        inj_req = 1'b1;
        repeat (2) @(negedge clk);
        check("t6_err_set", {31'd0, err_o}, 32'd1);
        check("t6_fifo_unchanged", {31'd0, res_valid_o}, 32'd0);
        repeat (3) @(negedge clk);
        check("t6_err_sticky", {31'd0, err_o}, 32'd1);
        @(posedge clk); #1;
        send(PE_MODE_COMP, 12'h123, 12'h456, 12'h0F0, 12'hF00, hs);
        wait_idle("t6_idle");
        check("t6_next_op_done", exp_q.size(), 32'd0);
        check("t6_err_still", {31'd0, err_o}, 32'd1);

        // reset with 3 ops in flight and 2 results buffered
        @(posedge clk); #1;
        res_ready_i = 1'b0;
        send(PE_MODE_NTT, 12'h321, 12'h001, 12'h002, 12'h003, hs);
        hl = hs;
        for (int i = 1; i < 5; i++) begin
            send(PE_MODE_NTT, W'(12'h300 + i), 12'h011, 12'h022, 12'h033, hs);
        end
        for (int k = 0; k < 20 && cyc < hl + 7; k++) @(negedge clk);
        check("t5_pre_buffered", {31'd0, res_valid_o}, 32'd1);
        rst = 1'b0;
        exp_q.delete();
        last_mode = PE_MODE_NTT;
        #1;
        check("t5_rst_pe_valid", {31'd0, pe_valid_o}, 32'd0);
        check("t5_rst_pe_a", {20'd0, pe_a_o}, 32'd0);
        check("t5_rst_res_valid", {31'd0, res_valid_o}, 32'd0);
        check("t5_rst_res_uv", {8'd0, res_u_o, res_v_o}, 32'd0);
        check("t5_rst_busy", {31'd0, busy_o}, 32'd0);
        check("t5_rst_err", {31'd0, err_o}, 32'd0);
        check("t5_rst_in_ready", {31'd0, in_ready_o}, 32'd0);
        check("t5_rst_ctrl", {29'd0, pe_ctrl_o}, {29'd0, PE_MODE_NTT});
        @(posedge clk); #1 rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t5_quiet_pe_valid", {31'd0, pe_valid_o}, 32'd0);
            check("t5_quiet_res_valid", {31'd0, res_valid_o}, 32'd0);
        end
        check("t5_late_err", {31'd0, err_o}, 32'd1);
        check("t5_idle", {31'd0, busy_o}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
